// File: rtl/clk_vec_edge_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : clk_vec_edge_monitor
//  Function : Per-channel edge counter for a bundled clock vector, with
//             completion events reported through a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module clk_vec_edge_monitor #(
    parameter int  NCH       = 4,
    parameter int  CNT_W     = 8,
    parameter int  TARGET    = 3,
    parameter int  EDGE_MODE = 0,
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       i_clks,
    input  logic [NCH-1:0]       i_en,
    input  logic                 i_clear,
    output logic [NCH*CNT_W-1:0] o_cnt,
    output logic [NCH-1:0]       o_done,
    output logic [NCH-1:0]       o_ovf,
    output logic                 o_all_done,
    output logic                 o_evt_valid,
    output logic [CH_W-1:0]      o_evt_ch,
    input  logic                 i_evt_ready
);

    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_COUNT = 2'd1;
    localparam logic [1:0]       c_DONE  = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(TARGET - 1);

    logic [NCH-1:0] r_s1;
    logic [NCH-1:0] r_s0;
    logic [NCH-1:0] w_edge;
    logic [NCH-1:0] w_done;
    logic [NCH-1:0] w_set;
    logic [NCH-1:0] w_ack;
    logic [NCH-1:0] w_ovf;
    logic [NCH-1:0] r_pend;
    logic           r_all_done;
    logic           w_valid;
    logic [CH_W-1:0] w_ch;

    // Two-stage sampler; deliberately untouched by i_clear so a clear
    // cannot manufacture an edge on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s0 <= '0;
        end else begin
            r_s1 <= i_clks;
            r_s0 <= r_s1;
        end
    end

    generate
        if (EDGE_MODE == 1) begin : g_fall
            assign w_edge = ~r_s1 & r_s0;
        end else if (EDGE_MODE == 2) begin : g_both
            assign w_edge = r_s1 ^ r_s0;
        end else begin : g_rise
            assign w_edge = r_s1 & ~r_s0;
        end
    endgenerate

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        logic [1:0]       r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;

        assign w_done[n] = (r_state == c_DONE);
        assign w_set[n]  = (r_state == c_COUNT) && i_en[n] && w_edge[n] && (r_cnt == c_LAST);
        assign w_ack[n]  = w_valid && i_evt_ready && (w_ch == CH_W'(n));
        assign w_ovf[n]  = r_ovf;
        assign o_cnt[n*CNT_W +: CNT_W] = r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else if (i_clear) begin
                r_state <= c_IDLE;
                r_cnt   <= '0;
                r_ovf   <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (i_en[n]) r_state <= c_COUNT;
                    end
                    c_COUNT: begin
                        if (!i_en[n]) begin
                            r_state <= c_IDLE;
                        end else if (w_edge[n]) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (r_cnt == c_LAST) r_state <= c_DONE;
                        end
                    end
                    c_DONE: begin
                        if (!i_en[n])       r_state <= c_IDLE;
                        else if (w_edge[n]) r_ovf   <= 1'b1;
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end
    end

    // Lowest-index pending channel wins the event port.
    always_comb begin
        w_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (r_pend[i]) w_ch = CH_W'(i);
        end
    end

    assign w_valid = |r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend     <= '0;
            r_all_done <= 1'b0;
        end else if (i_clear) begin
            r_pend     <= '0;
            r_all_done <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_ack) | w_set;
            r_all_done <= (|i_en) && (&(w_done | ~i_en));
        end
    end

    assign o_done      = w_done;
    assign o_ovf       = w_ovf;
    assign o_all_done  = r_all_done;
    assign o_evt_valid = w_valid;
    assign o_evt_ch    = w_ch;

endmodule
`default_nettype wire

// File: tb/tb_clk_vec_edge_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_vec_edge_monitor
//  Function : Scoreboard bench for clk_vec_edge_monitor (rising and both-edge
//             instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_vec_edge_monitor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]  a_clks, a_en, a_done, a_ovf;
    logic        a_clear, a_ready, a_all_done, a_evt_valid;
    logic [31:0] a_cnt;
    logic [1:0]  a_evt_ch;

    logic [3:0]  b_clks, b_en, b_done, b_ovf;
    logic        b_clear, b_ready, b_all_done, b_evt_valid;
    logic [31:0] b_cnt;
    logic [1:0]  b_evt_ch;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    clk_vec_edge_monitor #(.NCH(4), .CNT_W(8), .TARGET(3), .EDGE_MODE(0)) u_dut_rise (
        .clk(clk), .rst_n(rst_n), .i_clks(a_clks), .i_en(a_en), .i_clear(a_clear),
        .o_cnt(a_cnt), .o_done(a_done), .o_ovf(a_ovf), .o_all_done(a_all_done),
        .o_evt_valid(a_evt_valid), .o_evt_ch(a_evt_ch), .i_evt_ready(a_ready)
    );

    clk_vec_edge_monitor #(.NCH(4), .CNT_W(8), .TARGET(3), .EDGE_MODE(2)) u_dut_both (
        .clk(clk), .rst_n(rst_n), .i_clks(b_clks), .i_en(b_en), .i_clear(b_clear),
        .o_cnt(b_cnt), .o_done(b_done), .o_ovf(b_ovf), .o_all_done(b_all_done),
        .o_evt_valid(b_evt_valid), .o_evt_ch(b_evt_ch), .i_evt_ready(b_ready)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Rise on the masked channels, then fall; the rise is counted by return.
    task automatic pulse_a(input logic [3:0] m);
        a_clks = m;
        tick();
        a_clks = 4'h0;
        tick();
    endtask

    function automatic logic [7:0] cnt_of(input logic [31:0] v, input int n);
        return v[n*8 +: 8];
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_evt_valid && a_ready) begin
            if (exp_q.size() == 0) chk("evt_unexpected", 32'(a_evt_ch), 32'hFFFF_FFFF);
            else                   chk("evt_ch", 32'(a_evt_ch), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        a_clks  = 4'b1010;  b_clks  = 4'b0101;
        a_en    = 4'h0;     b_en    = 4'h0;
        a_clear = 1'b0;     b_clear = 1'b0;
        a_ready = 1'b0;     b_ready = 1'b0;
        #3;
        chk("rst_cnt", a_cnt, 32'h0);
        chk("rst_flags", 32'({a_done, a_ovf, a_all_done, a_evt_valid, a_evt_ch}), 32'h0);
        chk("rst_cnt_b", b_cnt, 32'h0);

        a_clks = 4'h0; b_clks = 4'h0;
        a_en = 4'hF; b_en = 4'b1000; a_ready = 1'b1;
        #9 rst_n = 1'b1;
        tick(2);

        // All four channels complete together; events drain one per cycle.
        pulse_a(4'hF);
        pulse_a(4'hF);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        pulse_a(4'hF);
        chk("s1_done", 32'(a_done), 32'hF);
        chk("s1_cnt", a_cnt, 32'h0303_0303);
        chk("s1_alldone_lag", 32'(a_all_done), 32'h0);
        tick();
        chk("s1_alldone", 32'(a_all_done), 32'h1);
        tick(4);
        chk("s1_drained", 32'(a_evt_valid), 32'h0);
        chk("s1_queue", 32'(exp_q.size()), 32'h0);

        // ch0 and ch2 complete in the same cycle with ready low.
        a_ready = 1'b0;
        a_clear = 1'b1; tick(); a_clear = 1'b0; tick();
        chk("clr_cnt", a_cnt, 32'h0);
        chk("clr_done", 32'(a_done), 32'h0);
        pulse_a(4'b0101);
        pulse_a(4'b0101);
        exp_q.push_back(0); exp_q.push_back(2);
        pulse_a(4'b0101);
        chk("s2_valid", 32'(a_evt_valid), 32'h1);
        chk("s2_ch", 32'(a_evt_ch), 32'h0);
        tick(3);
        chk("s2_hold_ch", 32'(a_evt_ch), 32'h0);
        chk("s2_hold_valid", 32'(a_evt_valid), 32'h1);
        a_ready = 1'b1; tick(); a_ready = 1'b0;
        chk("s2_next_ch", 32'(a_evt_ch), 32'h2);
        chk("s2_next_valid", 32'(a_evt_valid), 32'h1);
        a_ready = 1'b1; tick(); a_ready = 1'b0;
        chk("s2_empty", 32'(a_evt_valid), 32'h0);

        // ch1 completes then sees two extra rises.
        a_ready = 1'b1;
        pulse_a(4'b0010);
        pulse_a(4'b0010);
        exp_q.push_back(1);
        pulse_a(4'b0010);
        pulse_a(4'b0010);
        pulse_a(4'b0010);
        chk("s3_ovf", 32'(a_ovf), 32'h2);
        chk("s3_cnt1", 32'(cnt_of(a_cnt, 1)), 32'h3);
        chk("s3_done", 32'(a_done), 32'h7);
        chk("s3_queue", 32'(exp_q.size()), 32'h0);

        // Both-edge instance: a period counts twice, disable freezes the count.
        b_clks = 4'b1000; tick(); b_clks = 4'h0; tick(3);
        chk("m2_period", 32'(cnt_of(b_cnt, 3)), 32'h2);
        b_en = 4'h0; tick();
        b_clks = 4'b1000; tick(); b_clks = 4'h0; tick(3);
        chk("m2_held", 32'(cnt_of(b_cnt, 3)), 32'h2);
        b_en = 4'b1000; tick();
        b_clks = 4'b1000; tick(3);
        chk("m2_resume", 32'(cnt_of(b_cnt, 3)), 32'h3);
        chk("m2_done", 32'(b_done), 32'h8);
        chk("m2_evt", 32'({b_evt_valid, b_evt_ch}), 32'h7);
        chk("m2_alldone", 32'(b_all_done), 32'h1);
        chk("m2_ovf", 32'(b_ovf), 32'h0);

        // Clear lands with a final edge on ch1 and a handshake on ch0.
        a_ready = 1'b0;
        a_clear = 1'b1; tick(); a_clear = 1'b0; tick();
        pulse_a(4'b0011);
        pulse_a(4'b0011);
        exp_q.push_back(0);
        pulse_a(4'b0001);
        pulse_a(4'b0001);
        chk("s5_pre_ovf", 32'(a_ovf), 32'h1);
        chk("s5_pre_valid", 32'(a_evt_valid), 32'h1);
        a_clks = 4'b0010; tick();
        a_clear = 1'b1; a_ready = 1'b1; a_clks = 4'h0; tick();
        a_clear = 1'b0; a_ready = 1'b0;
        chk("s5_cnt", a_cnt, 32'h0);
        chk("s5_valid", 32'(a_evt_valid), 32'h0);
        chk("s5_ovf", 32'(a_ovf), 32'h0);
        tick();
        chk("s5_valid_after", 32'(a_evt_valid), 32'h0);
        chk("s5_queue", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-count, then restart from zero.
        tick();
        pulse_a(4'hF);
        chk("s6_pre_cnt", a_cnt, 32'h0101_0101);
        a_clks = 4'hF; tick();
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_cnt", a_cnt, 32'h0);
        chk("s6_rst_flags", 32'({a_done, a_ovf, a_all_done, a_evt_valid, a_evt_ch}), 32'h0);
        chk("s6_rst_b", 32'({b_cnt[31:24], b_done, b_all_done, b_evt_valid}), 32'h0);
        a_clks = 4'h0;
        #10 rst_n = 1'b1;
        tick(2);
        chk("s6_restart_zero", a_cnt, 32'h0);
        pulse_a(4'hF);
        chk("s6_restart_cnt", a_cnt, 32'h0101_0101);
        chk("s6_high_at_release", 32'(cnt_of(b_cnt, 3)), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_vec_edge_monitor.md
# clk_vec_edge_monitor

Parametrised multi-channel edge monitor for clock-vector regression designs. Samples an `NCH`-bit vector of clock-like inputs in the single `clk` domain, detects edges per channel in a selectable mode, counts them up to a target, and reports per-channel completion through a valid/ready event port. It sits beside clock-concatenation test hierarchies to check that every bit of a bundled clock vector toggles the expected number of times.

## Interface
- `NCH`, 4: number of monitored channels (1..32).
- `CNT_W`, 8: per-channel counter width; must satisfy 2**CNT_W > `TARGET`.
- `TARGET`, 3: edges per channel that complete it (>= 1).
- `EDGE_MODE`, 0: 0 = rising, 1 = falling, 2 = both edges.

- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `i_clks`  in  NCH  monitored signals, treated as data.
- `i_en`  in  NCH  per-channel enable.
- `i_clear`  in  1  synchronous clear of counters, flags, FSMs and pending events.
- `o_cnt`  out  NCH*CNT_W  counters, channel n at bits [n*CNT_W +: CNT_W].
- `o_done`  out  NCH  channel in DONE.
- `o_ovf`  out  NCH  sticky: an edge arrived while the channel was in DONE.
- `o_all_done`  out  1  registered; every enabled channel is in DONE and at least one is enabled.
- `o_evt_valid`  out  1  completion event pending.
- `o_evt_ch`  out  max(1,$clog2(NCH))  channel index of the presented event.
- `i_evt_ready`  in  1  consumer accepts the event.

## Operation
- Sampling: `s1 <= i_clks`, `s0 <= s1`. Edge per channel: rise = s1 & ~s0, fall = ~s1 & s0, both = s1 ^ s0, per `EDGE_MODE`.
- Per-channel FSM (states IDLE, COUNT, DONE):
  - IDLE: counter held. `i_en`=1 -> COUNT.
  - COUNT: on an edge, cnt <= cnt+1. An edge with cnt == TARGET-1 -> DONE (cnt becomes TARGET) and sets the channel's pending bit. `i_en`=0 -> IDLE, counter held, no edge counted that cycle.
  - DONE: counter frozen at TARGET. An edge sets `o_ovf`. `i_en`=0 -> IDLE; counter stays TARGET. On re-enable the FSM goes to COUNT; the next edge produces cnt = TARGET+1 (wraps mod 2**CNT_W) and no new event until cnt == TARGET-1 is reached again.
- Event port: `o_evt_ch` = lowest-index pending channel. `o_evt_valid` = any pending. Both are derived from registered pending bits and stay stable until accepted. On `o_evt_valid & i_evt_ready`, that channel's pending bit clears. A newly set pending bit and an accepted bit in the same cycle are independent.
- `i_clear` has priority over all else: FSMs -> IDLE; counters, `o_ovf`, pending bits and `o_all_done` -> 0. `s0`/`s1` are not cleared.
- Reset: every register, including `s0`/`s1`, -> 0. Every output is 0 during and after reset.

## Timing
- Input change is captured in `s1` at edge E0 and counted at E1. `o_cnt` reflects it after E1 (2-cycle latency).
- `o_done` and `o_evt_valid` rise after the same edge as the final count.
- `o_all_done` lags `o_done` by one cycle.
- Event acceptance: `o_evt_valid` drops, or moves to the next channel, one cycle after the handshake.
- Reset asserted mid-count zeroes state immediately. After release, pre-reset `i_clks` levels yield no spurious edge because `s0`/`s1` start at 0. A high input at release does count as one rising edge.

## Test plan
- Reset, `NCH`=4, `TARGET`=3, `EDGE_MODE`=0; toggle all channels 3 times with `i_en`=4'hF, ready=1 -> events for ch 0,1,2,3 in consecutive cycles; `o_done`=4'hF; `o_all_done`=1 one cycle later; `o_cnt`=3 each.
- Ready held 0 while ch2 and ch0 complete in the same cycle -> `o_evt_ch`=0 held stable. Assert ready for 1 cycle -> `o_evt_ch`=2. Second accept -> valid=0.
- ch1 completes, then 2 more rises -> `o_ovf[1]`=1, `o_cnt[1]` stays 3.
- `EDGE_MODE`=2, one full period on ch3 -> count increments by 2. `i_en[3]` dropped mid-count -> count held. Re-enabled -> counting resumes.
- `i_clear` in the same cycle as a final edge and a handshake -> all counters 0, `o_evt_valid`=0, `o_ovf`=0.
- `rst_n` pulsed low asynchronously mid-count -> all outputs 0 without a `clk` edge. Counting restarts from 0 after release.
